// File: rtl/fpu_request_controller.sv
// Request controller for the fixed-point unit: accepts one operation, qualifies the unit's
// ready with a per-operation minimum latency and a timeout, then returns a tagged response.
module fpu_request_controller #(
    parameter int WIDTH    = 32,
    parameter int TAG_W    = 5,
    parameter int MUL_LAT  = 6,
    parameter int SQRT_LAT = 24,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_operation,
    input  logic [WIDTH-1:0] req_operand_1,
    input  logic [WIDTH-1:0] req_operand_2,
    input  logic [TAG_W-1:0] req_tag,
    output logic [1:0]       fpu_operation,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_error,
    output logic             busy
);

    localparam logic [1:0] FPU_ADD  = 2'd0;
    localparam logic [1:0] FPU_SUB  = 2'd1;
    localparam logic [1:0] FPU_MUL  = 2'd2;
    localparam logic [1:0] FPU_SQRT = 2'd3;
    localparam int         CNT_W    = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state, state_nxt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opnd1_q, opnd2_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   lat_last_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic [WIDTH-1:0]   result_q;
    logic               error_q;
    logic               accept, capture, timeout, rsp_done;

    // Last WAIT count value (LAT-1) before which fpu_ready is ignored for this operation.
    function automatic logic [CNT_W-1:0] lat_last(input logic [1:0] op);
        case (op)
            FPU_MUL:  lat_last = CNT_W'(MUL_LAT - 1);
            FPU_SQRT: lat_last = CNT_W'(SQRT_LAT - 1);
            default:  lat_last = '0;
        endcase
    endfunction

    assign accept   = (state == S_IDLE) && req_valid;
    assign capture  = (state == S_WAIT) && (wait_cnt >= lat_last_q) && (fpu_ready == 1'b1);
    assign timeout  = (state == S_WAIT) && !capture && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign rsp_done = (state == S_RESP) && rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_WAIT;
            S_WAIT:  if (capture || timeout) state_nxt = S_RESP;
            S_RESP:  if (rsp_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch on accept; result/error capture and latency counting while waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= FPU_ADD;
            opnd1_q    <= '0;
            opnd2_q    <= '0;
            tag_q      <= '0;
            lat_last_q <= '0;
            wait_cnt   <= '0;
            result_q   <= '0;
            error_q    <= 1'b0;
        end else if (accept) begin
            op_q       <= req_operation;
            opnd1_q    <= req_operand_1;
            opnd2_q    <= req_operand_2;
            tag_q      <= req_tag;
            lat_last_q <= lat_last(req_operation);
            wait_cnt   <= '0;
        end else if (state == S_WAIT) begin
            if (capture) begin
                result_q <= fpu_result;
                error_q  <= 1'b0;
            end else if (timeout) begin
                result_q <= '0;
                error_q  <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // Outside WAIT the unit sees a harmless ADD of zeros so multi-cycle engines stay idle.
    assign fpu_operation = (state == S_WAIT) ? op_q    : FPU_ADD;
    assign fpu_operand_1 = (state == S_WAIT) ? opnd1_q : '0;
    assign fpu_operand_2 = (state == S_WAIT) ? opnd2_q : '0;

    assign req_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign rsp_valid  = (state == S_RESP);
    assign rsp_result = result_q;
    assign rsp_tag    = tag_q;
    assign rsp_error  = error_q;

endmodule

// File: doc/fpu_request_controller.md
# fpu_request_controller

Initiator-side controller for the fixed-point unit's operand/operation/result/ready interface. Accepts one arithmetic request at a time from the execute stage over a valid/ready handshake and drives the fixed-point unit's operands and operation code. It qualifies the unit's `ready` per operation with a minimum-latency counter and a timeout, then returns the captured result with its destination tag over a second valid/ready handshake. Sits between the execute-stage issue logic and the fixed-point unit.

## Interface
- `WIDTH`, 32, operand/result width.
- `TAG_W`, 5, destination-register tag width.
- `MUL_LAT`, 6, minimum WAIT cycles before `fpu_ready` is honoured for `FPU_MUL`.
- `SQRT_LAT`, 24, minimum WAIT cycles before `fpu_ready` is honoured for `FPU_SQRT`.
- `TIMEOUT`, 64, maximum WAIT cycles before an error response. Required: TIMEOUT > SQRT_LAT ≥ MUL_LAT ≥ 1.

One clock; reset is asynchronous and active-low.

- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_operation`  in  2  `FPU_ADD`/`FPU_SUB`/`FPU_MUL`/`FPU_SQRT` (shared defines).
- `req_operand_1`, `req_operand_2`  in  WIDTH  request operands.
- `req_tag`  in  TAG_W  destination tag.
- `fpu_operation`  out  2  operation code to the fixed-point unit.
- `fpu_operand_1`, `fpu_operand_2`  out  WIDTH  operands to the fixed-point unit.
- `fpu_result`  in  WIDTH  result from the fixed-point unit.
- `fpu_ready`  in  1  unit ready; any value other than 1 is treated as 0.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_tag`  out  TAG_W  tag of the completed request.
- `rsp_error`  out  1  response produced by timeout.
- `busy`  out  1  high in WAIT or RESP.

## Operation
- States:
  - IDLE: `req_ready` = 1.
    - `req_valid`&&`req_ready` latches operation, operands and tag.
    - Loads LAT (ADD/SUB = 1, MUL = MUL_LAT, SQRT = SQRT_LAT).
    - Clears `wait_cnt`; goes to WAIT.
  - WAIT: drives the latched operation and operands on the `fpu_*` outputs every cycle.
    - Capture (`wait_cnt` ≥ LAT−1 && `fpu_ready`): latch `fpu_result` into `rsp_result`, `rsp_error` = 0, go to RESP.
    - Timeout (`wait_cnt` == TIMEOUT−1 without capture): `rsp_result` = 0, `rsp_error` = 1, go to RESP.
    - Otherwise: increment `wait_cnt`.
  - RESP: `rsp_valid` = 1; `rsp_result`/`rsp_tag`/`rsp_error` stable. `rsp_valid`&&`rsp_ready` returns to IDLE.
- Idle drive:
  - In IDLE and RESP: `fpu_operation` = `FPU_ADD`, `fpu_operand_1`/`fpu_operand_2` = 0.
  - This keeps the unit's multi-cycle engines from restarting. A stale `ready` from a previous MUL/SQRT is masked by the LAT counter.
- No bypass: `req_ready` is 0 in WAIT and RESP, so at most one request is outstanding.
- `wait_cnt` width is ceil(log2(TIMEOUT))+1 bits and never wraps; it is cleared on every WAIT entry.
- Simultaneous events: a capture and a timeout in the same cycle resolve as capture.
- All outputs are registered or decoded from state only; there is no combinational path from `req_*` or `fpu_*` inputs to outputs.

## Timing
- Reset asserted, asynchronous:
  - State = IDLE, so `req_ready` = 1.
  - `rsp_valid` = 0, `rsp_result` = 0, `rsp_tag` = 0, `rsp_error` = 0, `busy` = 0.
  - `fpu_operation` = `FPU_ADD`, `fpu_operand_1`/`fpu_operand_2` = 0.
- Reset mid-operation abandons the request and emits no response.
- Accept edge = cycle 0. WAIT starts at cycle 1, and the `fpu_*` outputs carry the request from cycle 1.
- ADD/SUB with `fpu_ready` high: capture at the end of cycle 1; `rsp_valid` high from cycle 2.
- MUL: earliest `rsp_valid` at cycle MUL_LAT+1. SQRT: earliest at cycle SQRT_LAT+1.
- Timeout: `rsp_valid` at cycle TIMEOUT+1 with `rsp_error` = 1.
- Response handshake at cycle N: IDLE and `req_ready` = 1 from cycle N+1. Minimum issue interval is LAT+2 cycles.

## Test plan
- Reset low at mid-WAIT of a MUL → all outputs take their reset values immediately. After release, `req_ready` = 1 and no response appears.
- ADD 0x00000C00 + 0x00000400, tag 3, `fpu_ready` tied high, `rsp_ready` high → `rsp_valid` at cycle 2, `rsp_result` = 0x00001000, `rsp_tag` = 3, `rsp_error` = 0.
- MUL with `fpu_ready` held high from cycle 1 (stale), unit model returns 0x00000800 at cycle 6 → capture not before WAIT cycle 6, `rsp_valid` at cycle 7, `rsp_result` = 0x00000800.
- SQRT with `fpu_ready` never asserted → `rsp_valid` at cycle 65, `rsp_error` = 1, `rsp_result` = 0; `fpu_operation` = `FPU_SQRT` throughout WAIT.
- `rsp_ready` held low for 5 cycles after an ADD response → `rsp_valid`/`rsp_result`/`rsp_tag` stable, `req_ready` = 0 throughout. A new `req_valid` is not accepted until the cycle after the handshake.
- Back-to-back SUB then MUL with `req_valid` always high → `fpu_operation` goes SUB, then ADD (RESP), then MUL. Two responses come out in order with the correct tags.
